warp_register_file: RTL and testbench

// Per-core register file for all THREADS lanes of a block, with a warp-wide load scoreboard.

---
 rtl/warp_register_file.sv | 201 ++++++++++++++++++++
 tb/tb_warp_register_file.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_register_file.sv
// warp_register_file
//   Per-core register file covering every lane of a block, plus a warp-wide
//   scoreboard of registers with outstanding loads. Sits between the decoder,
//   ALUs and LSUs and the core scheduler.
//
//   Register map per lane: R0..RO_BASE-1 are general purpose. The top three
//   registers are read-only: %blockIdx (RO_BASE), %blockDim (RO_BASE+1) and
//   %threadIdx (RO_BASE+2).
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   - an operand read that coincides with an accepted writeback to
//                 the same register returns the writeback data, and that
//                 register is excluded from hazard in that cycle.
//     undefined - the read returns the stored value; hazard clears the cycle
//                 after the writeback handshake.
//
// Ports
//   clk, reset     clock; synchronous active-high reset
//   thread_mask    per-lane active flags (inactive lanes hold their state)
//   block_start    pulse: load block_id into %blockIdx of every lane
//   block_id       current block index
//   core_state     3'b011 REQUEST, 3'b110 UPDATE
//   rd/rs/rt_addr  decoded register addresses
//   reg_we         decoded register write enable
//   reg_mux        00 ARITH, 01 MEMORY, 10 CONST, 11 none
//   nzp_we         decoded NZP write enable
//   immediate      CONST value
//   alu_out        per-lane ALU results, lane t at [t*DATA_BITS +: DATA_BITS]
//   wb_valid/ready LSU writeback handshake
//   wb_addr        writeback destination register
//   wb_mask        lanes whose wb_data is written
//   wb_data        per-lane load results
//   rs, rt         per-lane operands (registered)
//   nzp            per-lane {n,z,p} flags (registered)
//   hazard         a decoded address has an outstanding load (combinational)
module warp_register_file #(
    parameter int THREADS   = 4,
    parameter int DATA_BITS = 8,
    parameter int NUM_REGS  = 16,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [THREADS-1:0]           thread_mask,
    input  logic                         block_start,
    input  logic [7:0]                   block_id,
    input  logic [2:0]                   core_state,
    input  logic [AW-1:0]                rd_addr,
    input  logic [AW-1:0]                rs_addr,
    input  logic [AW-1:0]                rt_addr,
    input  logic                         reg_we,
    input  logic [1:0]                   reg_mux,
    input  logic                         nzp_we,
    input  logic [DATA_BITS-1:0]         immediate,
    input  logic [THREADS*DATA_BITS-1:0] alu_out,
    input  logic                         wb_valid,
    output logic                         wb_ready,
    input  logic [AW-1:0]                wb_addr,
    input  logic [THREADS-1:0]           wb_mask,
    input  logic [THREADS*DATA_BITS-1:0] wb_data,
    output logic [THREADS*DATA_BITS-1:0] rs,
    output logic [THREADS*DATA_BITS-1:0] rt,
    output logic [THREADS*3-1:0]         nzp,
    output logic                         hazard
);

    typedef enum logic [2:0] {
        CORE_REQUEST = 3'b011,
        CORE_UPDATE  = 3'b110
    } core_state_e;

    typedef enum logic [1:0] {
        MUX_ARITH  = 2'b00,
        MUX_MEMORY = 2'b01,
        MUX_CONST  = 2'b10,
        MUX_NONE   = 2'b11
    } reg_mux_e;

    localparam logic [AW-1:0] IDX_ADDR = AW'(NUM_REGS - 3);
    localparam logic [AW-1:0] DIM_ADDR = AW'(NUM_REGS - 2);

    logic [DATA_BITS-1:0] block_idx;
    logic [NUM_REGS-1:0]  pending;
    logic [NUM_REGS-1:0]  pending_visible;
    logic                 wb_fire;
    logic                 upd_write;
    logic                 upd_mem;

    // %blockDim and %threadIdx are constants, so only %blockIdx is stored
    // (once, since every lane always holds the same value).
    function automatic logic [DATA_BITS-1:0] read_reg(
        input logic [AW-1:0]        addr,
        input logic [DATA_BITS-1:0] stored,
        input logic [DATA_BITS-1:0] idx,
        input logic [DATA_BITS-1:0] lane_id
    );
        logic [DATA_BITS-1:0] val;
        val = stored;
        if (addr == IDX_ADDR)
            val = idx;
        else if (addr == DIM_ADDR)
            val = DATA_BITS'(THREADS);
        else if (addr > DIM_ADDR)
            val = lane_id;
        return val;
    endfunction

    always_comb begin
        // Any UPDATE write to the writeback's register, including a load
        // issue, takes priority; the LSU is stalled for that cycle.
        wb_ready  = !((core_state == CORE_UPDATE) && reg_we &&
                      (reg_mux != MUX_NONE) && (rd_addr == wb_addr));
        wb_fire   = wb_valid && wb_ready;
        upd_write = (core_state == CORE_UPDATE) && reg_we && (rd_addr < IDX_ADDR);
        upd_mem   = upd_write && (reg_mux == MUX_MEMORY) && (|thread_mask);

        pending_visible = pending;
`ifdef REGFILE_BYPASS_EN
        if (wb_fire)
            pending_visible[wb_addr] = 1'b0;
`endif
        hazard = pending_visible[rs_addr] | pending_visible[rt_addr] |
                 pending_visible[rd_addr];
    end

    // Set is ordered after clear so a same-cycle set on one register wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= '0;
            block_idx <= '0;
        end else begin
            if (wb_fire)
                pending[wb_addr] <= 1'b0;
            if (upd_mem)
                pending[rd_addr] <= 1'b1;
            if (block_start)
                block_idx <= DATA_BITS'(block_id);
        end
    end

    for (genvar t = 0; t < THREADS; t = t + 1) begin : g_lane
        logic [DATA_BITS-1:0] regs [NUM_REGS];
        logic [DATA_BITS-1:0] alu_val;
        logic [DATA_BITS-1:0] wb_val;
        logic [DATA_BITS-1:0] rs_val;
        logic [DATA_BITS-1:0] rt_val;
        logic [DATA_BITS-1:0] rs_q;
        logic [DATA_BITS-1:0] rt_q;
        logic [2:0]           nzp_q;
        logic                 active;
        logic                 wb_hit;

        assign active  = thread_mask[t];
        assign alu_val = alu_out[t*DATA_BITS +: DATA_BITS];
        assign wb_val  = wb_data[t*DATA_BITS +: DATA_BITS];
        assign wb_hit  = wb_fire && wb_mask[t] && (wb_addr < IDX_ADDR);

        always_comb begin
            rs_val = read_reg(rs_addr, regs[rs_addr], block_idx, DATA_BITS'(t));
            rt_val = read_reg(rt_addr, regs[rt_addr], block_idx, DATA_BITS'(t));
`ifdef REGFILE_BYPASS_EN
            if (wb_hit && (rs_addr == wb_addr))
                rs_val = wb_val;
            if (wb_hit && (rt_addr == wb_addr))
                rt_val = wb_val;
`endif
        end

        // Writeback is applied first so a same-register UPDATE write wins;
        // in practice wb_ready already blocks that collision.
        always_ff @(posedge clk) begin
            if (reset) begin
                regs  <= '{default: '0};
                rs_q  <= '0;
                rt_q  <= '0;
                nzp_q <= '0;
            end else begin
                if (wb_hit)
                    regs[wb_addr] <= wb_val;
                if (upd_write && active) begin
                    case (reg_mux)
                        MUX_ARITH: regs[rd_addr] <= alu_val;
                        MUX_CONST: regs[rd_addr] <= immediate;
                        default:   ;
                    endcase
                end
                if ((core_state == CORE_REQUEST) && active) begin
                    rs_q <= rs_val;
                    rt_q <= rt_val;
                end
                if ((core_state == CORE_UPDATE) && nzp_we && active)
                    nzp_q <= alu_val[2:0];
            end
        end

        assign rs[t*DATA_BITS +: DATA_BITS] = rs_q;
        assign rt[t*DATA_BITS +: DATA_BITS] = rt_q;
        assign nzp[t*3 +: 3]                = nzp_q;
    end

endmodule

// File: tb/tb_warp_register_file.sv
module tb_warp_register_file;

    localparam int T  = 4;
    localparam int DB = 8;
    localparam int NR = 16;
    localparam int AW = 4;
    localparam int RO = NR - 3;

    logic            clk;
    logic            reset;
    logic [T-1:0]    thread_mask;
    logic            block_start;
    logic [7:0]      block_id;
    logic [2:0]      core_state;
    logic [AW-1:0]   rd_addr, rs_addr, rt_addr;
    logic            reg_we;
    logic [1:0]      reg_mux;
    logic            nzp_we;
    logic [DB-1:0]   immediate;
    logic [T*DB-1:0] alu_out;
    logic            wb_valid;
    logic            wb_ready;
    logic [AW-1:0]   wb_addr;
    logic [T-1:0]    wb_mask;
    logic [T*DB-1:0] wb_data;
    logic [T*DB-1:0] rs, rt;
    logic [T*3-1:0]  nzp;
    logic            hazard;

    int checks   = 0;
    int failures = 0;

    // Reference model: every register of every lane, read-only ones included.
    logic [DB-1:0]   mregs [T][NR];
    logic [NR-1:0]   mpend;
    logic [T*DB-1:0] exp_rs, exp_rt;
    logic [T*3-1:0]  exp_nzp;

    localparam logic [2:0] REQ = 3'b011;
    localparam logic [2:0] UPD = 3'b110;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    warp_register_file #(.THREADS(T), .DATA_BITS(DB), .NUM_REGS(NR)) dut (
        .clk(clk), .reset(reset), .thread_mask(thread_mask),
        .block_start(block_start), .block_id(block_id), .core_state(core_state),
        .rd_addr(rd_addr), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .reg_we(reg_we), .reg_mux(reg_mux), .nzp_we(nzp_we),
        .immediate(immediate), .alu_out(alu_out),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .wb_mask(wb_mask), .wb_data(wb_data),
        .rs(rs), .rt(rt), .nzp(nzp), .hazard(hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    function automatic bit m_ready();
        return !(core_state == UPD && reg_we && reg_mux != 2'b11 && rd_addr == wb_addr);
    endfunction

    function automatic bit m_hazard();
        logic [NR-1:0] p;
        p = mpend;
        if (BYPASS && wb_valid && m_ready()) p[wb_addr] = 1'b0;
        return p[rs_addr] | p[rt_addr] | p[rd_addr];
    endfunction

    task automatic model_reset();
        for (int t = 0; t < T; t++)
            for (int r = 0; r < NR; r++)
                mregs[t][r] = (r == RO + 1) ? DB'(T) : (r == RO + 2) ? DB'(t) : '0;
        mpend = '0; exp_rs = '0; exp_rt = '0; exp_nzp = '0;
    endtask

    task automatic model_step();
        logic [DB-1:0] nr [T][NR];
        logic [NR-1:0] np;
        bit fire;
        if (reset) begin
            model_reset();
            return;
        end
        nr = mregs; np = mpend;
        fire = wb_valid && m_ready();
        for (int t = 0; t < T; t++) begin
            if (core_state == REQ && thread_mask[t]) begin
                exp_rs[t*DB +: DB] = mregs[t][rs_addr];
                exp_rt[t*DB +: DB] = mregs[t][rt_addr];
                if (BYPASS && fire && wb_mask[t] && wb_addr < RO) begin
                    if (rs_addr == wb_addr) exp_rs[t*DB +: DB] = wb_data[t*DB +: DB];
                    if (rt_addr == wb_addr) exp_rt[t*DB +: DB] = wb_data[t*DB +: DB];
                end
            end
            if (fire && wb_mask[t] && wb_addr < RO)
                nr[t][wb_addr] = wb_data[t*DB +: DB];
            if (core_state == UPD && reg_we && rd_addr < RO && thread_mask[t]) begin
                if (reg_mux == 2'b00) nr[t][rd_addr] = alu_out[t*DB +: DB];
                if (reg_mux == 2'b10) nr[t][rd_addr] = immediate;
            end
            if (core_state == UPD && nzp_we && thread_mask[t])
                exp_nzp[t*3 +: 3] = alu_out[t*DB +: 3];
            if (block_start) nr[t][RO] = block_id;
        end
        if (fire) np[wb_addr] = 1'b0;
        if (core_state == UPD && reg_we && reg_mux == 2'b01 && rd_addr < RO && thread_mask != 0)
            np[rd_addr] = 1'b1;
        mregs = nr; mpend = np;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; block_start = 0; block_id = '0; core_state = 3'b000;
        rd_addr = '0; rs_addr = '0; rt_addr = '0; reg_we = 0; reg_mux = 2'b11;
        nzp_we = 0; immediate = '0; alu_out = '0; wb_valid = 0; wb_addr = '0;
        wb_mask = '0; wb_data = '0; thread_mask = '1;
    endtask

    task automatic test_reset();
        idle(); reset = 1; tick(); tick(); reset = 0;
        checks++; if (rs !== '0) begin failures++; $display("FAIL reset_rs actual=%h required=%h", rs, 32'h0); end
        checks++; if (nzp !== '0) begin failures++; $display("FAIL reset_nzp actual=%h required=%h", nzp, 12'h0); end
        core_state = REQ; rs_addr = 4'd15; rt_addr = 4'd14; #1;
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL reset_hazard actual=%b required=0", hazard); end
        tick(); idle();
        checks++; if (rs !== 32'h03020100) begin failures++; $display("FAIL reset_threadidx actual=%h required=%h", rs, 32'h03020100); end
        checks++; if (rt !== 32'h04040404) begin failures++; $display("FAIL reset_blockdim actual=%h required=%h", rt, 32'h04040404); end
    endtask

    task automatic test_block_start();
        idle(); block_start = 1; block_id = 8'h2A; thread_mask = 4'b0101; tick();
        idle(); core_state = REQ; rs_addr = 4'd13; tick(); idle();
        checks++; if (rs !== 32'h2A2A2A2A) begin failures++; $display("FAIL block_idx actual=%h required=%h", rs, 32'h2A2A2A2A); end
    endtask

    task automatic test_const_write();
        idle(); core_state = UPD; reg_we = 1; reg_mux = 2'b10; rd_addr = 4'd3;
        immediate = 8'h55; thread_mask = 4'b0101; tick();
        idle(); core_state = REQ; rs_addr = 4'd3; tick(); idle();
        checks++; if (rs !== 32'h00550055) begin failures++; $display("FAIL const_masked actual=%h required=%h", rs, 32'h00550055); end
        core_state = UPD; reg_we = 1; reg_mux = 2'b10; rd_addr = 4'd14; immediate = 8'h55; tick();
        idle(); core_state = REQ; rs_addr = 4'd14; tick(); idle();
        checks++; if (rs !== 32'h04040404) begin failures++; $display("FAIL const_ro_ignored actual=%h required=%h", rs, 32'h04040404); end
    endtask

    task automatic test_nzp();
        idle(); core_state = UPD; nzp_we = 1; alu_out = 32'hFC0A0304; thread_mask = 4'b1011; tick(); idle();
        checks++; if (nzp !== 12'h81C) begin failures++; $display("FAIL nzp_write actual=%h required=%h", nzp, 12'h81C); end
    endtask

    task automatic test_memory_wb();
        idle(); core_state = UPD; reg_we = 1; reg_mux = 2'b01; rd_addr = 4'd5; tick();
        idle(); rs_addr = 4'd5; #1;
        checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL load_hazard actual=%b required=1", hazard); end
        wb_valid = 1; wb_addr = 4'd5; wb_data = 32'h44332211; wb_mask = 4'hF; #1;
        checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL wb_ready_free actual=%b required=1", wb_ready); end
        checks++; if (hazard !== !BYPASS) begin failures++; $display("FAIL hazard_during_wb actual=%b required=%b", hazard, !BYPASS); end
        tick(); idle(); rs_addr = 4'd5; #1;
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL hazard_after_wb actual=%b required=0", hazard); end
        core_state = REQ; tick(); idle();
        checks++; if (rs !== 32'h44332211) begin failures++; $display("FAIL wb_data actual=%h required=%h", rs, 32'h44332211); end
        // reset while a load is outstanding
        core_state = UPD; reg_we = 1; reg_mux = 2'b01; rd_addr = 4'd6; tick();
        idle(); reset = 1; tick(); reset = 0; rs_addr = 4'd6; #1;
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL reset_clears_pending actual=%b required=0", hazard); end
        wb_valid = 1; wb_addr = 4'd6; wb_data = 32'hDDCCBBAA; wb_mask = 4'hF; #1;
        checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL late_wb_ready actual=%b required=1", wb_ready); end
        tick(); idle(); core_state = REQ; rs_addr = 4'd6; tick(); idle();
        checks++; if (rs !== 32'hDDCCBBAA) begin failures++; $display("FAIL late_wb_data actual=%h required=%h", rs, 32'hDDCCBBAA); end
    endtask

    task automatic test_update_conflict();
        idle(); core_state = UPD; reg_we = 1; reg_mux = 2'b00; rd_addr = 4'd7; alu_out = 32'hA4A3A2A1;
        wb_valid = 1; wb_addr = 4'd7; wb_data = 32'hB4B3B2B1; wb_mask = 4'hF; #1;
        checks++; if (wb_ready !== 1'b0) begin failures++; $display("FAIL conflict_stall actual=%b required=0", wb_ready); end
        tick(); core_state = REQ; reg_we = 0; rs_addr = 4'd7; #1;
        checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL conflict_release actual=%b required=1", wb_ready); end
        tick();
        checks++; if (rs !== (BYPASS ? 32'hB4B3B2B1 : 32'hA4A3A2A1)) begin failures++;
            $display("FAIL conflict_alu_then_wb actual=%h required=%h", rs, BYPASS ? 32'hB4B3B2B1 : 32'hA4A3A2A1); end
        idle(); core_state = REQ; rs_addr = 4'd7; tick(); idle();
        checks++; if (rs !== 32'hB4B3B2B1) begin failures++; $display("FAIL conflict_wb_overwrite actual=%h required=%h", rs, 32'hB4B3B2B1); end
        // distinct registers: both writes land in one cycle
        core_state = UPD; reg_we = 1; reg_mux = 2'b10; rd_addr = 4'd8; immediate = 8'h77;
        wb_valid = 1; wb_addr = 4'd9; wb_data = 32'hC4C3C2C1; wb_mask = 4'b0011; #1;
        checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL distinct_ready actual=%b required=1", wb_ready); end
        tick(); idle(); core_state = REQ; rs_addr = 4'd8; rt_addr = 4'd9; tick(); idle();
        checks++; if (rs !== 32'h77777777) begin failures++; $display("FAIL distinct_update actual=%h required=%h", rs, 32'h77777777); end
        checks++; if (rt !== 32'h0000C2C1) begin failures++; $display("FAIL distinct_wb actual=%h required=%h", rt, 32'h0000C2C1); end
    endtask

    task automatic test_bypass();
        idle(); core_state = UPD; reg_we = 1; reg_mux = 2'b10; rd_addr = 4'd5; immediate = 8'h5A; tick();
        idle(); core_state = REQ; rs_addr = 4'd5; wb_valid = 1; wb_addr = 4'd5;
        wb_data = 32'h99999999; wb_mask = 4'hF; tick(); idle();
        checks++; if (rs !== (BYPASS ? 32'h99999999 : 32'h5A5A5A5A)) begin failures++;
            $display("FAIL bypass_read actual=%h required=%h", rs, BYPASS ? 32'h99999999 : 32'h5A5A5A5A); end
        core_state = REQ; rs_addr = 4'd5; tick(); idle();
        checks++; if (rs !== 32'h99999999) begin failures++; $display("FAIL bypass_stored actual=%h required=%h", rs, 32'h99999999); end
    endtask

    task automatic test_random();
        logic [2:0] states [4];
        states[0] = REQ; states[1] = UPD; states[2] = 3'b000; states[3] = UPD;
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 79) == 0);
            block_start = ($urandom_range(0, 15) == 0);
            block_id    = 8'($urandom);
            core_state  = states[$urandom_range(0, 3)];
            rd_addr     = 4'($urandom); rs_addr = 4'($urandom); rt_addr = 4'($urandom);
            reg_we      = 1'($urandom); reg_mux = 2'($urandom); nzp_we = 1'($urandom);
            immediate   = 8'($urandom); alu_out = 32'($urandom);
            thread_mask = 4'($urandom_range(1, 15));
            wb_valid    = 1'($urandom); wb_mask = 4'($urandom); wb_data = 32'($urandom);
            wb_addr     = ($urandom_range(0, 1) == 0) ? rd_addr : 4'($urandom);
            if ($urandom_range(0, 2) == 0) rs_addr = wb_addr;
            #1;
            checks++; if (wb_ready !== m_ready()) begin failures++; $display("FAIL rand_wb_ready i=%0d actual=%b required=%b", i, wb_ready, m_ready()); end
            checks++; if (hazard !== m_hazard()) begin failures++; $display("FAIL rand_hazard i=%0d actual=%b required=%b", i, hazard, m_hazard()); end
            tick();
            checks++; if (rs !== exp_rs) begin failures++; $display("FAIL rand_rs i=%0d actual=%h required=%h", i, rs, exp_rs); end
            checks++; if (rt !== exp_rt) begin failures++; $display("FAIL rand_rt i=%0d actual=%h required=%h", i, rt, exp_rt); end
            checks++; if (nzp !== exp_nzp) begin failures++; $display("FAIL rand_nzp i=%0d actual=%h required=%h", i, nzp, exp_nzp); end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_block_start();
        test_const_write();
        test_nzp();
        test_memory_wb();
        test_update_conflict();
        test_bypass();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
